gbsb_step_scheduler: RTL and testbench
======================================

// Module: gbsb_step_scheduler
// PURPOSE
//  Sequences one GbSB annealing run: per step, fires the Jx matrix-vector unit, then the momentum
//  update (y_next = y - dt*(p*x - Jx)), then the position update. Owns the step counter and the
//  pump ramp p, and broadcasts p/dt to all N oscillator lanes. Sits between host config and the
//  update datapaths; the datapaths themselves are unchanged.
// PARAMETERS
//  DATA_WIDTH  32  fixed-point word width (signed, two's complement)
//  FRAC_WIDTH  16  fractional bits of p/dt words
//  STEP_W      16  width of step count / index
//  WDOG_W      12  watchdog counter width; timeout = 2**WDOG_W-1 cycles in any wait state
// PORTS
//  clk            in   1           clock
//  rst_n          in   1           reset, asynchronous, active-low
//  start          in   1           1-cycle pulse: latch config, begin run (ignored while busy)
//  abort          in   1           level: terminate run, return to IDLE
//  num_steps      in   STEP_W      steps to run (latched on start)
//  dt_cfg         in   DATA_WIDTH  time step dt (latched on start)
//  p_inc          in   DATA_WIDTH  pump increment per step (latched, signed)
//  p_max          in   DATA_WIDTH  pump ceiling (latched, signed)
//  mvm_start      out  1           1-cycle pulse to Jx unit
//  mvm_done       in   1           1-cycle pulse: Jx valid
//  mom_valid_in   out  1           1-cycle pulse to momentum update
//  mom_valid_out  in   1           momentum update result valid
//  pos_valid_in   out  1           1-cycle pulse to position update
//  pos_valid_out  in   1           position update result valid
//  p_out          out  DATA_WIDTH  current pump value, stable for a whole step
//  dt_out         out  DATA_WIDTH  latched dt
//  step_idx       out  STEP_W      steps completed in this run
//  busy           out  1           high from cycle after accepted start until FINISH/IDLE
//  done           out  1           1-cycle pulse at successful run end
//  error          out  1           sticky watchdog timeout; cleared by next accepted start
// BEHAVIOUR
//  Reset: state IDLE; all outputs 0 (p_out, dt_out, step_idx = 0; pulses low; error low).
//  FSM: IDLE -> MVM_REQ -> MVM_WAIT -> MOM_REQ -> MOM_WAIT -> POS_REQ -> POS_WAIT -> ADVANCE.
//   ADVANCE -> MVM_REQ if step_idx+1 < num_steps, else FINISH; FINISH -> IDLE.
//  start in IDLE: latch num_steps/dt_cfg/p_inc/p_max, p_out<=0, step_idx<=0, error<=0, go MVM_REQ.
//   num_steps==0: go FINISH directly; done pulses 2 cycles after start, no mvm_start issued.
//  *_REQ states last exactly 1 cycle and assert the matching *_valid_in/mvm_start (registered).
//  *_WAIT states hold until the matching done/valid_out pulse; a pulse outside its WAIT is ignored.
//  ADVANCE: step_idx<=step_idx+1; p_out<=sat(p_out+p_inc) clamped to p_max (signed compare,
//   sum computed at DATA_WIDTH+1 bits so overflow cannot wrap past p_max); p_out unchanged
//   within a step.
//  FINISH: done=1 for one cycle, busy drops same cycle as done; p_out/step_idx hold last values.
//  Min step latency with 1-cycle responders: 7 cycles (3 REQ + 3 WAIT + ADVANCE).
//  abort (any state except IDLE): next state IDLE, busy<=0, no done, error unchanged; abort and
//   start in same cycle -> abort wins, start dropped.
//  Watchdog: cleared on every state entry; counts in WAIT states; at all-ones -> error<=1, IDLE.
//  step_idx wraps never: num_steps bounds it (max 2**STEP_W-1 steps).
//  Async reset mid-run: immediate return to reset values; datapath pulses drop at once.
// STRUCTURE
//  gbsb_pkg: typedef fx_t (logic signed [DATA_WIDTH-1:0]), sched_state_e enum, fx_sat_add func.
//  Sub-module gbsb_pump_ramp: registered saturating accumulator (clear, en, inc, max -> p).
//  Watchdog and FSM inline.
// TESTING
//  num_steps=3, dt=0x0000_1000, p_inc=0x0000_4000, p_max=0x0001_0000, 1-cycle responders ->
//   3 mvm/mom/pos pulses in order, p_out 0,0x4000,0x8000 during steps 0..2, done at end, step_idx=3.
//  p_inc=0x0000_8000, p_max=0x0000_C000, num_steps=4 -> p_out 0,0x8000,0xC000,0xC000 (clamped).
//  num_steps=0 -> done pulse 2 cycles after start, zero mvm_start pulses, busy high 1 cycle.
//  mvm_done withheld in step 1 -> error=1 after 4095 cycles, IDLE, no done; next start clears error.
//  abort asserted in MOM_WAIT of step 2 (same cycle as mom_valid_out) -> IDLE next cycle,
//   no pos_valid_in, no done; start+abort same cycle in IDLE -> stays IDLE.
//  start pulsed while busy and stray mom_valid_out in MVM_WAIT -> both ignored, run completes normally.

Source files
------------

// File: rtl/gbsb_pkg.sv
// Shared types and fixed-point helpers for the GbSB step scheduler slice.
// fx_t is the signed two's-complement word used for p, dt and the pump ramp.
package gbsb_pkg;

   localparam int DATA_WIDTH = 32;
   localparam int FRAC_WIDTH = 16;

   typedef logic signed [DATA_WIDTH-1:0] fx_t;

   typedef enum logic [3:0] {
      S_IDLE     = 4'd0,
      S_MVM_REQ  = 4'd1,
      S_MVM_WAIT = 4'd2,
      S_MOM_REQ  = 4'd3,
      S_MOM_WAIT = 4'd4,
      S_POS_REQ  = 4'd5,
      S_POS_WAIT = 4'd6,
      S_ADVANCE  = 4'd7,
      S_FINISH   = 4'd8
   } sched_state_e;

   localparam fx_t FX_MIN = {1'b1, {(DATA_WIDTH-1){1'b0}}};

   // Sum is formed one bit wider so an overflowing add clamps instead of wrapping past the ceiling.
   function automatic fx_t fx_sat_add(input fx_t a, input fx_t b, input fx_t ceil_v);
      logic signed [DATA_WIDTH:0] sum;
      logic signed [DATA_WIDTH:0] ceil_x;
      logic signed [DATA_WIDTH:0] floor_x;
      fx_t                        res;
      sum     = $signed({a[DATA_WIDTH-1], a}) + $signed({b[DATA_WIDTH-1], b});
      ceil_x  = $signed({ceil_v[DATA_WIDTH-1], ceil_v});
      floor_x = $signed({FX_MIN[DATA_WIDTH-1], FX_MIN});
      if (sum > ceil_x) begin
         res = ceil_v;
      end else if (sum < floor_x) begin
         res = FX_MIN;
      end else begin
         res = fx_t'(sum[DATA_WIDTH-1:0]);
      end
      return res;
   endfunction

endpackage

// File: rtl/gbsb_pump_ramp.sv
// Registered saturating pump accumulator: clear to zero, or add inc clamped to max when enabled.
module gbsb_pump_ramp
   import gbsb_pkg::*;
(
   input  logic clk,
   input  logic rst_n,
   input  logic clear_i,
   input  logic en_i,
   input  fx_t  inc_i,
   input  fx_t  max_i,
   output fx_t  p_o
);

   fx_t p_q;
   fx_t p_d;

   // Next pump value: clear has priority over a ramp step.
   always_comb begin
      p_d = p_q;
      if (clear_i) begin
         p_d = {DATA_WIDTH{1'b0}};
      end else if (en_i) begin
         p_d = fx_sat_add(p_q, inc_i, max_i);
      end else begin
         p_d = p_q;
      end
   end

   // Pump register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         p_q <= {DATA_WIDTH{1'b0}};
      end else begin
         p_q <= p_d;
      end
   end

   assign p_o = p_q;

endmodule

// File: rtl/gbsb_step_scheduler.sv
// Sequences one GbSB annealing run: Jx MVM, momentum update, position update per step,
// then advances the step counter and pump ramp; a watchdog bounds every wait state.
module gbsb_step_scheduler
   import gbsb_pkg::*;
#(
   parameter int STEP_W = 16,
   parameter int WDOG_W = 12
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  start,
   input  logic                  abort,
   input  logic [STEP_W-1:0]     num_steps,
   input  logic [DATA_WIDTH-1:0] dt_cfg,
   input  logic [DATA_WIDTH-1:0] p_inc,
   input  logic [DATA_WIDTH-1:0] p_max,
   output logic                  mvm_start,
   input  logic                  mvm_done,
   output logic                  mom_valid_in,
   input  logic                  mom_valid_out,
   output logic                  pos_valid_in,
   input  logic                  pos_valid_out,
   output logic [DATA_WIDTH-1:0] p_out,
   output logic [DATA_WIDTH-1:0] dt_out,
   output logic [STEP_W-1:0]     step_idx,
   output logic                  busy,
   output logic                  done,
   output logic                  error
);

   localparam logic [WDOG_W-1:0] WDOG_ALL   = {WDOG_W{1'b1}};
   localparam logic [WDOG_W-1:0] WDOG_ZERO  = {WDOG_W{1'b0}};
   localparam logic [WDOG_W-1:0] WDOG_ONE   = {{(WDOG_W-1){1'b0}}, 1'b1};
   localparam logic [STEP_W-1:0] STEP_ZERO  = {STEP_W{1'b0}};
   localparam logic [STEP_W:0]   STEP_ONE_X = {{STEP_W{1'b0}}, 1'b1};

   sched_state_e          state_q, state_d;
   logic [STEP_W-1:0]     step_idx_q, step_idx_d;
   logic [WDOG_W-1:0]     wdog_q, wdog_d;
   logic                  error_q, error_d;
   logic                  done_q, done_d;
   logic                  busy_q;
   logic                  mvm_start_q, mom_valid_q, pos_valid_q;
   logic [STEP_W-1:0]     num_steps_q;
   logic [DATA_WIDTH-1:0] dt_q;
   fx_t                   p_inc_q, p_max_q, p_s;

   logic                  run_abort_s;
   logic                  latch_s;
   logic                  pump_clear_s;
   logic                  pump_en_s;
   logic                  in_wait_s;
   logic                  wdog_expire_s;
   logic [WDOG_W-1:0]     wdog_inc_s;
   logic [STEP_W:0]       step_next_s;

   // Next-state, step counter, error and pump control decode.
   always_comb begin
      state_d       = state_q;
      step_idx_d    = step_idx_q;
      error_d       = error_q;
      done_d        = 1'b0;
      latch_s       = 1'b0;
      pump_clear_s  = 1'b0;
      pump_en_s     = 1'b0;
      run_abort_s   = abort && (state_q != S_IDLE);
      in_wait_s     = (state_q inside {S_MVM_WAIT, S_MOM_WAIT, S_POS_WAIT});
      wdog_inc_s    = wdog_q + WDOG_ONE;
      wdog_expire_s = (wdog_inc_s == WDOG_ALL);
      step_next_s   = {1'b0, step_idx_q} + STEP_ONE_X;

      if (run_abort_s) begin
         state_d = S_IDLE;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (start && !abort) begin
                  latch_s      = 1'b1;
                  pump_clear_s = 1'b1;
                  step_idx_d   = STEP_ZERO;
                  error_d      = 1'b0;
                  state_d      = (num_steps == STEP_ZERO) ? S_FINISH : S_MVM_REQ;
               end else begin
                  state_d = S_IDLE;
               end
            end
            S_MVM_REQ: state_d = S_MVM_WAIT;
            S_MVM_WAIT: begin
               if (mvm_done) begin
                  state_d = S_MOM_REQ;
               end else if (wdog_expire_s) begin
                  state_d = S_IDLE;
                  error_d = 1'b1;
               end else begin
                  state_d = S_MVM_WAIT;
               end
            end
            S_MOM_REQ: state_d = S_MOM_WAIT;
            S_MOM_WAIT: begin
               if (mom_valid_out) begin
                  state_d = S_POS_REQ;
               end else if (wdog_expire_s) begin
                  state_d = S_IDLE;
                  error_d = 1'b1;
               end else begin
                  state_d = S_MOM_WAIT;
               end
            end
            S_POS_REQ: state_d = S_POS_WAIT;
            S_POS_WAIT: begin
               if (pos_valid_out) begin
                  state_d = S_ADVANCE;
               end else if (wdog_expire_s) begin
                  state_d = S_IDLE;
                  error_d = 1'b1;
               end else begin
                  state_d = S_POS_WAIT;
               end
            end
            S_ADVANCE: begin
               step_idx_d = step_next_s[STEP_W-1:0];
               pump_en_s  = 1'b1;
               state_d    = (step_next_s < {1'b0, num_steps_q}) ? S_MVM_REQ : S_FINISH;
            end
            S_FINISH: begin
               done_d  = 1'b1;
               state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
         endcase
      end

      // Watchdog restarts on every state entry and only advances while parked in a wait state.
      if (state_d != state_q) begin
         wdog_d = WDOG_ZERO;
      end else if (in_wait_s) begin
         wdog_d = wdog_inc_s;
      end else begin
         wdog_d = WDOG_ZERO;
      end
   end

   // FSM state, counters and registered handshake/status outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= S_IDLE;
         step_idx_q  <= STEP_ZERO;
         wdog_q      <= WDOG_ZERO;
         error_q     <= 1'b0;
         done_q      <= 1'b0;
         busy_q      <= 1'b0;
         mvm_start_q <= 1'b0;
         mom_valid_q <= 1'b0;
         pos_valid_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         step_idx_q  <= step_idx_d;
         wdog_q      <= wdog_d;
         error_q     <= error_d;
         done_q      <= done_d;
         busy_q      <= (state_d != S_IDLE);
         mvm_start_q <= (state_d == S_MVM_REQ);
         mom_valid_q <= (state_d == S_MOM_REQ);
         pos_valid_q <= (state_d == S_POS_REQ);
      end
   end

   // Run configuration captured on an accepted start.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         num_steps_q <= STEP_ZERO;
         dt_q        <= {DATA_WIDTH{1'b0}};
         p_inc_q     <= {DATA_WIDTH{1'b0}};
         p_max_q     <= {DATA_WIDTH{1'b0}};
      end else if (latch_s) begin
         num_steps_q <= num_steps;
         dt_q        <= dt_cfg;
         p_inc_q     <= fx_t'(p_inc);
         p_max_q     <= fx_t'(p_max);
      end
   end

   gbsb_pump_ramp u_pump_ramp (
      .clk     (clk),
      .rst_n   (rst_n),
      .clear_i (pump_clear_s),
      .en_i    (pump_en_s),
      .inc_i   (p_inc_q),
      .max_i   (p_max_q),
      .p_o     (p_s)
   );

   assign mvm_start    = mvm_start_q;
   assign mom_valid_in = mom_valid_q;
   assign pos_valid_in = pos_valid_q;
   assign p_out        = p_s;
   assign dt_out       = dt_q;
   assign step_idx     = step_idx_q;
   assign busy         = busy_q;
   assign done         = done_q;
   assign error        = error_q;

endmodule

// File: tb/tb_gbsb_step_scheduler.sv
// Directed bench for gbsb_step_scheduler with behavioural Jx/momentum/position responders.
module tb_gbsb_step_scheduler;

   logic        clk;
   logic        rst_n;
   logic        start;
   logic        abort;
   logic [15:0] num_steps;
   logic [31:0] dt_cfg;
   logic [31:0] p_inc;
   logic [31:0] p_max;
   logic        mvm_start;
   logic        mvm_done;
   logic        mom_valid_in;
   logic        mom_valid_out;
   logic        pos_valid_in;
   logic        pos_valid_out;
   logic [31:0] p_out;
   logic [31:0] dt_out;
   logic [15:0] step_idx;
   logic        busy;
   logic        done;
   logic        error;

   int tests = 0;
   int fails = 0;

   // responder configuration (written by the stimulus block only)
   int mvm_lat    = 1;
   int block_step = -1;
   int stray_step = -1;

   // run observations
   int          n_mvm, n_mom, n_pos, n_done;
   int          done_cyc, err_cyc, busy_cyc, last_mvm_cyc, stop_cyc, order_bad;
   logic        timed_out;
   logic [31:0] p_log [8];

   gbsb_step_scheduler dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .start         (start),
      .abort         (abort),
      .num_steps     (num_steps),
      .dt_cfg        (dt_cfg),
      .p_inc         (p_inc),
      .p_max         (p_max),
      .mvm_start     (mvm_start),
      .mvm_done      (mvm_done),
      .mom_valid_in  (mom_valid_in),
      .mom_valid_out (mom_valid_out),
      .pos_valid_in  (pos_valid_in),
      .pos_valid_out (pos_valid_out),
      .p_out         (p_out),
      .dt_out        (dt_out),
      .step_idx      (step_idx),
      .busy          (busy),
      .done          (done),
      .error         (error)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Responders: Jx answers mvm_lat cycles after its request, the updates answer after one.
   initial begin
      int   mvm_cnt;
      logic mom_pend, pos_pend, stray;
      mvm_cnt = 0; mom_pend = 1'b0; pos_pend = 1'b0;
      mvm_done = 1'b0; mom_valid_out = 1'b0; pos_valid_out = 1'b0;
      forever begin
         @(negedge clk);
         stray = 1'b0;
         if (mvm_start) begin
            mvm_cnt  = mvm_lat;
            mvm_done = 1'b0;
         end else if (mvm_cnt > 0) begin
            mvm_cnt  = mvm_cnt - 1;
            mvm_done = (mvm_cnt == 0) && (int'(step_idx) != block_step);
            stray    = (mvm_lat > 1) && (mvm_cnt == mvm_lat - 1) && (int'(step_idx) == stray_step);
         end else begin
            mvm_done = 1'b0;
         end
         mom_valid_out = mom_pend || stray;
         mom_pend      = mom_valid_in;
         pos_valid_out = pos_pend;
         pos_pend      = pos_valid_in;
      end
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Called on a negedge: present config with start high for one cycle.
   task automatic pulse_start(input logic [15:0] ns, input logic [31:0] dt,
                              input logic [31:0] inc, input logic [31:0] mx);
      num_steps = ns; dt_cfg = dt; p_inc = inc; p_max = mx;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
   endtask

   // Observe a run from the first busy cycle until done or busy drops, within a cycle budget.
   task automatic watch(input int budget, input int start_cyc, input int abort_step);
      int          phase;
      int          abort_cyc;
      logic [31:0] step_p;
      n_mvm = 0; n_mom = 0; n_pos = 0; n_done = 0; order_bad = 0;
      done_cyc = -1; err_cyc = -1; busy_cyc = 0; last_mvm_cyc = -1; stop_cyc = -1;
      timed_out = 1'b1; phase = 0; abort_cyc = -1; step_p = 32'h0;
      for (int cyc = 0; cyc < budget; cyc++) begin
         if (busy) busy_cyc++;
         if (error && err_cyc < 0) err_cyc = cyc;
         if (mvm_start) begin
            if (phase != 0) order_bad++;
            phase = 1;
            if (n_mvm < 8) p_log[n_mvm] = p_out;
            step_p = p_out;
            n_mvm++;
            last_mvm_cyc = cyc;
         end
         if (mom_valid_in) begin
            if (phase != 1 || p_out !== step_p) order_bad++;
            phase = 2;
            n_mom++;
            if (int'(step_idx) == abort_step) abort_cyc = cyc + 1;
         end
         if (pos_valid_in) begin
            if (phase != 2 || p_out !== step_p) order_bad++;
            phase = 0;
            n_pos++;
         end
         if (done) begin
            n_done++;
            if (done_cyc < 0) done_cyc = cyc;
         end
         abort = (cyc == abort_cyc);
         start = (cyc == start_cyc);
         if (done || !busy) begin
            timed_out = 1'b0;
            stop_cyc  = cyc;
            break;
         end
         @(negedge clk);
      end
      abort = 1'b0;
      start = 1'b0;
   endtask

   initial begin
      rst_n = 1'b0; start = 1'b0; abort = 1'b0;
      num_steps = 16'h0; dt_cfg = 32'h0; p_inc = 32'h0; p_max = 32'h0;
      repeat (3) @(negedge clk);

      // reset values
      chk("rst_busy", busy, 1'b0);
      chk("rst_done", done, 1'b0);
      chk("rst_error", error, 1'b0);
      chk("rst_mvm_start", mvm_start, 1'b0);
      chk("rst_p_out", p_out, 32'h0);
      chk("rst_dt_out", dt_out, 32'h0);
      chk("rst_step_idx", step_idx, 16'h0);
      rst_n = 1'b1;
      @(negedge clk);

      // three-step run, 1-cycle responders
      pulse_start(16'd3, 32'h0000_1000, 32'h0000_4000, 32'h0001_0000);
      watch(200, -1, -1);
      chk("t1_timeout", timed_out, 1'b0);
      chk("t1_n_mvm", n_mvm, 3);
      chk("t1_n_mom", n_mom, 3);
      chk("t1_n_pos", n_pos, 3);
      chk("t1_order", order_bad, 0);
      chk("t1_p0", p_log[0], 32'h0000_0000);
      chk("t1_p1", p_log[1], 32'h0000_4000);
      chk("t1_p2", p_log[2], 32'h0000_8000);
      chk("t1_done_cyc", done_cyc, 22);
      chk("t1_busy_at_done", busy, 1'b0);
      chk("t1_step_idx", step_idx, 16'd3);
      chk("t1_p_final", p_out, 32'h0000_C000);
      chk("t1_dt_out", dt_out, 32'h0000_1000);
      @(negedge clk);
      chk("t1_done_one_cycle", done, 1'b0);

      // pump clamps at p_max
      pulse_start(16'd4, 32'h0000_1000, 32'h0000_8000, 32'h0000_C000);
      watch(200, -1, -1);
      chk("t2_p0", p_log[0], 32'h0000_0000);
      chk("t2_p1", p_log[1], 32'h0000_8000);
      chk("t2_p2", p_log[2], 32'h0000_C000);
      chk("t2_p3", p_log[3], 32'h0000_C000);
      chk("t2_done_cyc", done_cyc, 29);
      chk("t2_step_idx", step_idx, 16'd4);
      chk("t2_p_final", p_out, 32'h0000_C000);

      // zero-step run
      @(negedge clk);
      pulse_start(16'd0, 32'h0000_0800, 32'h0000_1000, 32'h0000_4000);
      watch(50, -1, -1);
      chk("t3_done_cyc", done_cyc, 1);
      chk("t3_n_mvm", n_mvm, 0);
      chk("t3_busy_cycles", busy_cyc, 1);
      chk("t3_p_cleared", p_out, 32'h0);
      chk("t3_step_idx", step_idx, 16'd0);

      // start while busy and a stray momentum response in MVM_WAIT are both ignored
      @(negedge clk);
      mvm_lat = 3; stray_step = 0;
      pulse_start(16'd2, 32'h0000_2000, 32'h0000_1000, 32'h7FFF_FFFF);
      dt_cfg = 32'hDEAD_BEEF; num_steps = 16'd7;
      watch(200, 3, -1);
      chk("t4_done_cyc", done_cyc, 19);
      chk("t4_n_mvm", n_mvm, 2);
      chk("t4_n_mom", n_mom, 2);
      chk("t4_order", order_bad, 0);
      chk("t4_p1", p_log[1], 32'h0000_1000);
      chk("t4_step_idx", step_idx, 16'd2);
      chk("t4_dt_held", dt_out, 32'h0000_2000);
      mvm_lat = 1; stray_step = -1;

      // abort in MOM_WAIT of step 2, together with mom_valid_out
      @(negedge clk);
      pulse_start(16'd4, 32'h0000_1000, 32'h0000_1000, 32'h0001_0000);
      watch(200, -1, 2);
      chk("t5_timeout", timed_out, 1'b0);
      chk("t5_stop_cyc", stop_cyc, 18);
      chk("t5_n_pos", n_pos, 2);
      chk("t5_n_done", n_done, 0);
      chk("t5_step_idx", step_idx, 16'd2);
      chk("t5_p_held", p_out, 32'h0000_2000);
      chk("t5_error", error, 1'b0);
      @(negedge clk);
      chk("t5_no_pos_after", pos_valid_in, 1'b0);
      chk("t5_no_done_after", done, 1'b0);

      // start and abort together in IDLE
      start = 1'b1; abort = 1'b1; num_steps = 16'd2;
      @(negedge clk);
      start = 1'b0; abort = 1'b0;
      chk("t6_busy", busy, 1'b0);
      chk("t6_mvm_start", mvm_start, 1'b0);

      // watchdog: Jx never answers in step 1
      block_step = 1;
      pulse_start(16'd3, 32'h0000_1000, 32'h0000_1000, 32'h0001_0000);
      watch(5000, -1, -1);
      chk("t7_timeout", timed_out, 1'b0);
      chk("t7_wdog_cycles", err_cyc - last_mvm_cyc, 4096);
      chk("t7_error", error, 1'b1);
      chk("t7_busy", busy, 1'b0);
      chk("t7_n_done", n_done, 0);
      chk("t7_n_mvm", n_mvm, 2);
      chk("t7_step_idx", step_idx, 16'd1);
      block_step = -1;

      // dropped start leaves the sticky error alone
      @(negedge clk);
      start = 1'b1; abort = 1'b1;
      @(negedge clk);
      start = 1'b0; abort = 1'b0;
      chk("t8_error_sticky", error, 1'b1);
      chk("t8_busy", busy, 1'b0);

      // next accepted start clears error
      pulse_start(16'd1, 32'h0000_1000, 32'h0000_1000, 32'h0001_0000);
      chk("t9_error_cleared", error, 1'b0);
      watch(100, -1, -1);
      chk("t9_done_cyc", done_cyc, 8);
      chk("t9_step_idx", step_idx, 16'd1);

      // async reset mid-run
      @(negedge clk);
      pulse_start(16'd5, 32'h0000_3000, 32'h0000_1000, 32'h0001_0000);
      chk("t10_mvm_before", mvm_start, 1'b1);
      rst_n = 1'b0;
      #1;
      chk("t10_mvm_drop", mvm_start, 1'b0);
      chk("t10_busy", busy, 1'b0);
      chk("t10_dt_out", dt_out, 32'h0);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      chk("t10_idle", busy, 1'b0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
